// File: rtl/miopatia_pkg.sv
// Shared types and defaults for the miopatia arithmetic units.
package miopatia_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    FINALI = 3'd2
  } sq_state_t;

  localparam int unsigned SQ_W_DEF = 8;

endpackage

// File: rtl/cuadrador_seq.sv
// Sequential shift-and-add squarer: Y = X*X over W iterations, START/FIN level handshake.
module cuadrador_seq
  import miopatia_pkg::*;
#(
  parameter int unsigned W = SQ_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [W-1:0]     X,
  output logic             FIN,
  output logic             BUSY,
  output logic [2*W-1:0]   Y
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  sq_state_t        state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   x_sh_q, x_sh_d;
  logic [W-1:0]     m_sh_q, m_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   y_q, y_d;
  logic [2*W-1:0]   sum;

  // Next-state, datapath step and FIN/BUSY decode from the current state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_sh_d  = x_sh_q;
    m_sh_d  = m_sh_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    FIN     = 1'b0;
    BUSY    = 1'b0;
    sum     = acc_q + (m_sh_q[0] ? x_sh_q : '0);

    case (state_q)
      IDLE: begin
        if (START) begin
          x_sh_d  = {{W{1'b0}}, X};
          m_sh_d  = X;
          acc_d   = '0;
          cnt_d   = '0;
          y_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        BUSY   = 1'b1;
        acc_d  = sum;
        x_sh_d = x_sh_q << 1;
        m_sh_d = m_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // The last partial product is folded straight into Y on the exit edge.
        if (cnt_q == CNT_LAST) begin
          y_d     = sum;
          state_d = FINALI;
        end
      end
      FINALI: begin
        FIN = 1'b1;
        if (!START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset discards any in-flight result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_q   <= '0;
      x_sh_q  <= '0;
      m_sh_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_sh_q  <= x_sh_d;
      m_sh_q  <= m_sh_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign Y = y_q;

endmodule
